// File: rtl/vector_addsub.sv
// Lane-serial vector add/subtract with wrap or signed-saturate per operation.
// One lane is computed per cycle; outputs are registered and held until the next accepted start.
module vector_addsub #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       cout,
    output logic [LANES-1:0]       ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LANES*WIDTH-1:0] r_a;
    logic [LANES*WIDTH-1:0] r_b;
    logic [1:0]             r_op;
    logic [IDX_W-1:0]       r_idx;
    logic [LANES*WIDTH-1:0] r_result;
    logic [LANES-1:0]       r_cout;
    logic [LANES-1:0]       r_ovf;

    logic signed [WIDTH-1:0] w_a_lane;
    logic signed [WIDTH-1:0] w_b_lane;
    logic signed [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]          w_sum;
    logic                    w_lane_ovf;
    logic signed [WIDTH-1:0] w_lane_res;

    // Overflow when both addends share a sign that the sum does not.
    function automatic logic ovf_flag(
        input logic sign_a,
        input logic sign_b,
        input logic sign_s
    );
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_lane(
        input logic signed [WIDTH-1:0] a_l,
        input logic [WIDTH-1:0]        sum_l,
        input logic                    ovf_l
    );
        if (!ovf_l)
            return $signed(sum_l);
        else if (a_l[WIDTH-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_BUSY;
            S_BUSY:  if (r_idx == LAST_IDX) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Subtraction reuses the adder as A + ~B + 1, so cout=1 means no borrow.
    always_comb begin
        w_a_lane   = r_a[r_idx*WIDTH +: WIDTH];
        w_b_lane   = r_b[r_idx*WIDTH +: WIDTH];
        w_b_eff    = r_op[0] ? ~w_b_lane : w_b_lane;
        w_sum      = {1'b0, w_a_lane} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_op[0]};
        w_lane_ovf = ovf_flag(w_a_lane[WIDTH-1], w_b_eff[WIDTH-1], w_sum[WIDTH-1]);
        w_lane_res = r_op[1] ? sat_lane(w_a_lane, w_sum[WIDTH-1:0], w_lane_ovf)
                             : $signed(w_sum[WIDTH-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= '0;
            r_ovf    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_cout   <= '0;
                        r_ovf    <= '0;
                    end
                end
                S_BUSY: begin
                    r_result[r_idx*WIDTH +: WIDTH] <= w_lane_res;
                    r_cout[r_idx]                  <= w_sum[WIDTH];
                    r_ovf[r_idx]                   <= w_lane_ovf;
                    if (r_idx != LAST_IDX)
                        r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_vector_addsub.sv
// Directed bench for vector_addsub (WIDTH=8, LANES=4) with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge.
module tb_vector_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [3:0]  cout;
    logic [3:0]  ovf;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // Lane 0 is the least-significant byte.
    localparam logic [31:0] A1       = 32'h10FF7F01;
    localparam logic [31:0] B1       = 32'h20010101;
    localparam logic [31:0] R_ADD    = 32'h30008002;
    localparam logic [31:0] R_ADDSAT = 32'h30007F02;
    localparam logic [31:0] A2       = 32'h7F058000;
    localparam logic [31:0] B2       = 32'hFF050101;
    localparam logic [31:0] R_SUB    = 32'h80007FFF;
    localparam logic [31:0] R_SUBSAT = 32'h7F0080FF;

    vector_addsub #(.WIDTH(8), .LANES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one operation and returns the number of rising edges until done is seen (-1 on timeout).
    task automatic do_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int lat);
        @(negedge clk);
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ndone;
        int dseen;
        int nd;
        int low;
        int dt [3];

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_cout",   32'(cout), 0);
        check("rst_ovf",    32'(ovf), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        rst = 1'b0;

        do_op(2'b00, A1, B1, lat);
        check("add_latency", lat, 5);
        check("add_result",  result, R_ADD);
        check("add_cout",    32'(cout), 32'h4);
        check("add_ovf",     32'(ovf), 32'h2);
        check("add_busy_in_done", 32'(busy), 1);
        @(negedge clk);
        check("add_done_one_cycle", 32'(done), 0);
        check("add_idle_busy", 32'(busy), 0);
        check("add_hold_result", result, R_ADD);

        do_op(2'b10, A1, B1, lat);
        check("addsat_latency", lat, 5);
        check("addsat_result",  result, R_ADDSAT);
        check("addsat_ovf",     32'(ovf), 32'h2);
        check("addsat_cout",    32'(cout), 32'h4);

        do_op(2'b01, A2, B2, lat);
        check("sub_latency", lat, 5);
        check("sub_result",  result, R_SUB);
        check("sub_cout",    32'(cout), 32'h6);
        check("sub_ovf",     32'(ovf), 32'hA);

        do_op(2'b11, A2, B2, lat);
        check("subsat_result", result, R_SUBSAT);
        check("subsat_ovf",    32'(ovf), 32'hA);
        check("subsat_cout",   32'(cout), 32'h6);

        // start re-pulsed with different operands while BUSY and while DONE
        @(negedge clk);
        op    = 2'b00;
        a     = A1;
        b     = B1;
        start = 1'b1;
        ndone = 0;
        dseen = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    dseen = k;
                    check("ign_result", result, R_ADD);
                    check("ign_cout",   32'(cout), 32'h4);
                    check("ign_ovf",    32'(ovf), 32'h2);
                end
            end
            if (k == 7 || k == 8) check("ign_no_restart", 32'(busy), 0);
            case (k)
                1: begin start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; op = 2'b11; end
                2: start = 1'b1;
                3: start = 1'b0;
                5: start = 1'b1;
                6: start = 1'b0;
                default: ;
            endcase
        end
        check("ign_done_count", ndone, 1);
        check("ign_done_time",  dseen, 5);

        // reset during the second BUSY cycle
        @(negedge clk);
        op    = 2'b01;
        a     = A2;
        b     = B2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   32'(busy), 0);
        check("abort_done",   32'(done), 0);
        check("abort_result", result, 0);
        check("abort_cout",   32'(cout), 0);
        check("abort_ovf",    32'(ovf), 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(2'b01, A2, B2, lat);
        check("after_abort_latency", lat, 5);
        check("after_abort_result",  result, R_SUB);
        check("after_abort_cout",    32'(cout), 32'h6);

        // start held high continuously
        @(negedge clk);
        op    = 2'b00;
        a     = A1;
        b     = B1;
        start = 1'b1;
        nd    = 0;
        low   = 0;
        dt    = '{0, 0, 0};
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 3) dt[nd] = k;
                nd++;
                check("held_result", result, R_ADD);
            end
            if (!busy && nd >= 1 && nd < 3) low++;
        end
        start = 1'b0;
        check("held_first_done", dt[0], 5);
        check("held_period_1", dt[1] - dt[0], 6);
        check("held_period_2", dt[2] - dt[1], 6);
        check("held_busy_low", low, 2);
        check("held_done_count", nd, 4);
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
